pe_ws_dbuf: RTL and testbench
=============================

// Module: pe_ws_dbuf
// PURPOSE
//  Parametrised weight-stationary systolic processing element with double-buffered weights.
//  - Activations flow left->right; partial sums flow up->down.
//  - Weights daisy-chain down the column into a shadow register. A swap copies them into the
//    active register, so the next tile loads while the current tile computes.
//  - Adds valid tracking, global stall, bypass mode, signed/unsigned arithmetic, and optional
//    saturation with a sticky overflow flag.
// PARAMETERS
//  DATA_W  8   activation/weight width
//  PSUM_W  24  partial-sum width (must be >= 2*DATA_W)
//  SIGNED  1   1: two's-complement operands and psum; 0: unsigned
//  SAT_EN  1   1: saturate psum on overflow; 0: wrap modulo 2^PSUM_W
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  en            in   1       global enable; 0 freezes every register (stall)
//  mode          in   1       0: MAC, 1: BYPASS
//  in_left       in   DATA_W  activation from left neighbour
//  in_left_vld   in   1       activation valid
//  in_up         in   PSUM_W  partial sum from upper neighbour
//  in_up_vld     in   1       psum valid; 0 means psum treated as 0
//  w_in          in   DATA_W  weight from upper neighbour (chain)
//  w_load        in   1       capture w_in into shadow
//  w_swap        in   1       shadow -> active
//  clr_ovf       in   1       clear sticky overflow flag
//  out_right     out  DATA_W  registered activation to right neighbour
//  out_right_vld out  1       registered in_left_vld
//  out_down      out  PSUM_W  registered partial sum to lower neighbour
//  out_down_vld  out  1       registered (in_left_vld | in_up_vld)
//  w_out         out  DATA_W  shadow register value, feeds next PE's w_in
//  w_shadow_vld  out  1       shadow holds an unswapped weight
//  ovf           out  1       sticky: saturation/wrap event occurred
// BEHAVIOUR
//  - Reset: every output, shadow reg, active reg and flag = 0.
//  - en=0: all registers hold, including weights and ovf. w_load, w_swap and clr_ovf are ignored.
//  - Latency: 1 cycle from in_* to out_*; no combinational path from input to output.
//  - Weight buffer FSM (en=1):
//    - EMPTY --w_load--> FULL.
//    - FULL --w_swap--> EMPTY (active<=shadow).
//    - FULL --w_load--> FULL (shadow overwritten).
//    - w_swap in EMPTY: no-op, active unchanged.
//    - w_load & w_swap in FULL: active<=old shadow, shadow<=w_in, stay FULL.
//    - w_load & w_swap in EMPTY: shadow<=w_in, active unchanged, -> FULL.
//    - w_shadow_vld = (state==FULL); w_out = shadow.
//  - Swap timing: a swap in cycle N affects MACs issued from cycle N+1. The cycle-N MAC uses
//    the old active weight.
//  - Data path (en=1):
//    - in_left_vld=1: out_right<=in_left, out_right_vld<=1.
//    - in_left_vld=0: out_right<=0, out_right_vld<=0.
//    - psum_in = in_up_vld ? in_up : 0.
//    - MAC: in_left_vld=1 -> out_down<=sat(psum_in + in_left*active).
//      in_left_vld=0 -> out_down<=psum_in.
//    - BYPASS: out_down<=psum_in; no arithmetic; ovf never set.
//    - out_down_vld <= in_left_vld | in_up_vld. If both valids are 0, out_down<=0.
//  - Arithmetic:
//    - Product is 2*DATA_W, sign- or zero-extended per SIGNED to PSUM_W+1.
//    - Sum is computed at PSUM_W+1 bits.
//    - Overflow (result outside the PSUM_W range): SAT_EN=1 clamps to max/min, SAT_EN=0 keeps
//      the low PSUM_W bits. Either way ovf<=1.
//    - ovf clear: clr_ovf clears it. A new overflow in the same cycle wins (ovf stays 1).
//  - Mid-operation reset: everything returns to reset values at once; any in-flight psum is lost.
//  - mode may change on any cycle; it takes effect for the data sampled that cycle.
// STRUCTURE
//  - Shared package pe_pkg holds:
//    - MODE_MAC/MODE_BYPASS constants and the weight FSM state encoding (EMPTY/FULL);
//    - localparam helpers PSUM_MAX/PSUM_MIN per SIGNED.
//  - One sub-module, pe_sat_add: (PSUM_W+1)-bit add plus clamp/wrap, combinational;
//    outputs sum and overflow.
//  - Top holds the FSM, weight registers and output pipeline registers.
// TESTING (DATA_W=8, PSUM_W=24, SIGNED=1 unless stated)
//  1. Reset then swap without load: check all outputs 0 and w_shadow_vld=0. Then w_swap alone
//     -> active stays 0; in_left=5, vld=1, in_up=7, vld=1 -> out_down=7 next cycle.
//  2. w_load w_in=-3, then w_swap, then in_left=4, in_up=10 -> out_down=-2, out_right=4,
//     both vlds=1 exactly 1 cycle later.
//  3. Double buffer: active=2 and computing. w_load 9 on the same cycle as a MAC
//     (in_left=3, in_up=0) -> out_down=6. Then w_swap and the next MAC (in_left=3) -> 27.
//     Also check load+swap in the same cycle.
//  4. Saturation: in_up=0x7FFFFF, in_left=127, active=127 -> out_down=0x7FFFFF, ovf=1.
//     Same with SAT_EN=0 -> out_down=0x803F00, ovf=1. clr_ovf -> ovf=0.
//  5. Stall: en=0 for 3 cycles while toggling every input -> all outputs and weights
//     unchanged. BYPASS with in_up=0x123456 -> out_down=0x123456, ovf unchanged.
//  6. Async reset mid-MAC stream -> outputs 0 before the next clk edge; FSM returns to EMPTY.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the weight-stationary processing element.
//   MODE_MAC / MODE_BYPASS : values of the pe_ws_dbuf mode input
//   wbuf_state_e           : weight double-buffer state (EMPTY / FULL)
//   psum_max / psum_min    : partial-sum range limits for a given width and signedness,
//                            used by the datapath to build its PSUM_MAX / PSUM_MIN localparams
//                            (valid for widths up to 63 bits)
package pe_pkg;

    localparam logic MODE_MAC    = 1'b0;
    localparam logic MODE_BYPASS = 1'b1;

    typedef enum logic {
        W_EMPTY = 1'b0,
        W_FULL  = 1'b1
    } wbuf_state_e;

    function automatic logic [63:0] psum_max(input int unsigned w, input bit sgn);
        if (sgn)
            return (64'd1 << (w - 1)) - 64'd1;
        else
            return (64'd1 << w) - 64'd1;
    endfunction

    // Signed minimum is returned as its two's-complement bit pattern; callers truncate to w bits.
    function automatic logic [63:0] psum_min(input int unsigned w, input bit sgn);
        if (sgn)
            return 64'd1 << (w - 1);
        else
            return 64'd0;
    endfunction

endpackage

// File: rtl/pe_sat_add.sv
// pe_sat_add: combinational partial-sum accumulate with clamp or wrap.
//   psum  in  PSUM_W    incoming partial sum
//   prod  in  2*DATA_W  activation * weight product
//   sum   out PSUM_W    psum + prod, clamped (SAT_EN=1) or wrapped (SAT_EN=0)
//   ovf   out 1         true sum lies outside the PSUM_W range
// Both operands are extended to PSUM_W+1 bits so the exact sum is always representable.
module pe_sat_add
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 24,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT_EN = 1'b1
) (
    input  logic [PSUM_W-1:0]   psum,
    input  logic [2*DATA_W-1:0] prod,
    output logic [PSUM_W-1:0]   sum,
    output logic                ovf
);

    localparam int EXT_W = PSUM_W + 1 - 2 * DATA_W;
    localparam logic [PSUM_W-1:0] PSUM_MAX = PSUM_W'(psum_max(PSUM_W, SIGNED));
    localparam logic [PSUM_W-1:0] PSUM_MIN = PSUM_W'(psum_min(PSUM_W, SIGNED));

    logic signed [PSUM_W:0] psum_ext;
    logic signed [PSUM_W:0] prod_ext;
    logic signed [PSUM_W:0] sum_ext;

    // Signed: the top two bits disagree when the result left the range.
    // Unsigned: the extra bit is a carry out of PSUM_W bits.
    function automatic logic out_of_range(input logic signed [PSUM_W:0] s);
        if (SIGNED)
            return s[PSUM_W] ^ s[PSUM_W-1];
        else
            return s[PSUM_W];
    endfunction

    // The extension bit holds the true sign, so it chooses which rail to clamp to.
    function automatic logic [PSUM_W-1:0] clamp_or_wrap(input logic signed [PSUM_W:0] s);
        if (!SAT_EN || !out_of_range(s))
            return s[PSUM_W-1:0];
        else if (SIGNED && s[PSUM_W])
            return PSUM_MIN;
        else
            return PSUM_MAX;
    endfunction

    always_comb begin
        psum_ext = SIGNED ? {psum[PSUM_W-1], psum} : {1'b0, psum};
        prod_ext = SIGNED ? {{EXT_W{prod[2*DATA_W-1]}}, prod} : {{EXT_W{1'b0}}, prod};
        sum_ext  = psum_ext + prod_ext;
        sum      = clamp_or_wrap(sum_ext);
        ovf      = out_of_range(sum_ext);
    end

endmodule

// File: rtl/pe_ws_dbuf.sv
// pe_ws_dbuf: weight-stationary systolic PE with a double-buffered weight.
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   en                         0 stalls every register
//   mode                       MODE_MAC or MODE_BYPASS
//   in_left, in_left_vld       activation from the left neighbour
//   in_up, in_up_vld           partial sum from above (treated as 0 when not valid)
//   w_in, w_load, w_swap       weight chain input, capture into shadow, shadow -> active
//   clr_ovf                    clear the sticky overflow flag
//   out_right, out_right_vld   registered activation to the right neighbour
//   out_down, out_down_vld     registered partial sum to the lower neighbour
//   w_out, w_shadow_vld        shadow weight (chains to the next PE) and its occupancy
//   ovf                        sticky overflow flag
module pe_ws_dbuf
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 24,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_left,
    input  logic              in_left_vld,
    input  logic [PSUM_W-1:0] in_up,
    input  logic              in_up_vld,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_load,
    input  logic              w_swap,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] out_right,
    output logic              out_right_vld,
    output logic [PSUM_W-1:0] out_down,
    output logic              out_down_vld,
    output logic [DATA_W-1:0] w_out,
    output logic              w_shadow_vld,
    output logic              ovf
);

    wbuf_state_e state, state_nxt;
    logic        shadow_ld;
    logic        do_swap;

    logic [DATA_W-1:0] w_shadow;
    logic [DATA_W-1:0] w_active;

    logic signed [DATA_W-1:0]   act_s;
    logic signed [DATA_W-1:0]   wgt_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0]        prod_u;
    logic [2*DATA_W-1:0]        prod;
    logic [PSUM_W-1:0]          psum_in;
    logic [PSUM_W-1:0]          mac_sum;
    logic                       mac_ovf;
    logic [PSUM_W-1:0]          down_nxt;
    logic                       ovf_evt;

    logic [DATA_W-1:0] right_p0;
    logic              vld_right_p0;
    logic [PSUM_W-1:0] down_p0;
    logic              vld_down_p0;
    logic              ovf_p0;

    // Weight buffer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= W_EMPTY;
        else if (en)
            state <= state_nxt;
    end

    // A swap is only honoured when the shadow holds a weight. Load and swap together in FULL
    // move the old shadow into active while the new weight lands in shadow.
    always_comb begin
        state_nxt = state;
        shadow_ld = 1'b0;
        do_swap   = 1'b0;
        case (state)
            W_EMPTY: begin
                if (w_load) begin
                    shadow_ld = 1'b1;
                    state_nxt = W_FULL;
                end
            end
            W_FULL: begin
                if (w_swap) begin
                    do_swap   = 1'b1;
                    state_nxt = W_EMPTY;
                end
                if (w_load) begin
                    shadow_ld = 1'b1;
                    state_nxt = W_FULL;
                end
            end
            default: state_nxt = W_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_shadow <= '0;
            w_active <= '0;
        end else if (en) begin
            if (shadow_ld)
                w_shadow <= w_in;
            if (do_swap)
                w_active <= w_shadow;
        end
    end

    // The MAC reads w_active before this cycle's swap lands, so a swap only affects later MACs.
    always_comb begin
        act_s   = $signed(in_left);
        wgt_s   = $signed(w_active);
        prod_s  = act_s * wgt_s;
        prod_u  = in_left * w_active;
        prod    = SIGNED ? $unsigned(prod_s) : prod_u;
        psum_in = in_up_vld ? in_up : '0;
    end

    pe_sat_add #(
        .DATA_W (DATA_W),
        .PSUM_W (PSUM_W),
        .SIGNED (SIGNED),
        .SAT_EN (SAT_EN)
    ) u_sat_add (
        .psum (psum_in),
        .prod (prod),
        .sum  (mac_sum),
        .ovf  (mac_ovf)
    );

    // Without any valid input psum_in is already 0, which gives the required idle output.
    always_comb begin
        down_nxt = psum_in;
        ovf_evt  = 1'b0;
        if (mode == MODE_MAC && in_left_vld) begin
            down_nxt = mac_sum;
            ovf_evt  = mac_ovf;
        end
    end

    // Stage p0: output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            right_p0     <= '0;
            vld_right_p0 <= 1'b0;
            down_p0      <= '0;
            vld_down_p0  <= 1'b0;
            ovf_p0       <= 1'b0;
        end else if (en) begin
            right_p0     <= in_left_vld ? in_left : '0;
            vld_right_p0 <= in_left_vld;
            down_p0      <= down_nxt;
            vld_down_p0  <= in_left_vld | in_up_vld;
            ovf_p0       <= ovf_evt | (ovf_p0 & ~clr_ovf);
        end
    end

    assign out_right     = right_p0;
    assign out_right_vld = vld_right_p0;
    assign out_down      = down_p0;
    assign out_down_vld  = vld_down_p0;
    assign ovf           = ovf_p0;
    assign w_out         = w_shadow;
    assign w_shadow_vld  = (state == W_FULL);

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Scoreboard bench for pe_ws_dbuf. Two instances share stimulus: dut_a saturates, dut_b wraps.
module tb_pe_ws_dbuf;

    logic        clk = 1'b0;
    logic        rst, en, mode;
    logic [7:0]  in_left, w_in;
    logic        in_left_vld, in_up_vld, w_load, w_swap, clr_ovf;
    logic [23:0] in_up;

    logic [7:0]  a_right, b_right, a_wout, b_wout;
    logic        a_rvld, b_rvld, a_dvld, b_dvld, a_svld, b_svld, a_ovf, b_ovf;
    logic [23:0] a_down, b_down;

    logic en_seen = 1'b0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [23:0] down;
        logic [7:0]  right;
        logic        rvld;
        logic        ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    pe_ws_dbuf #(.DATA_W(8), .PSUM_W(24), .SIGNED(1'b1), .SAT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .in_left(in_left), .in_left_vld(in_left_vld), .in_up(in_up), .in_up_vld(in_up_vld),
        .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .clr_ovf(clr_ovf),
        .out_right(a_right), .out_right_vld(a_rvld), .out_down(a_down), .out_down_vld(a_dvld),
        .w_out(a_wout), .w_shadow_vld(a_svld), .ovf(a_ovf)
    );

    pe_ws_dbuf #(.DATA_W(8), .PSUM_W(24), .SIGNED(1'b1), .SAT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .in_left(in_left), .in_left_vld(in_left_vld), .in_up(in_up), .in_up_vld(in_up_vld),
        .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .clr_ovf(clr_ovf),
        .out_right(b_right), .out_right_vld(b_rvld), .out_down(b_down), .out_down_vld(b_dvld),
        .w_out(b_wout), .w_shadow_vld(b_svld), .ovf(b_ovf)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // An output is new only if the last edge was enabled.
    always @(posedge clk) en_seen <= en;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && en_seen && a_dvld) begin
            if (qa.size() == 0) begin
                check("a_unexpected_output", 32'(a_down), 32'hDEAD_BEEF);
            end else begin
                e = qa.pop_front();
                check("a_down",  32'(a_down),  32'(e.down));
                check("a_right", 32'(a_right), 32'(e.right));
                check("a_rvld",  32'(a_rvld),  32'(e.rvld));
                check("a_ovf",   32'(a_ovf),   32'(e.ovf));
            end
        end
        if (!rst && en_seen && b_dvld) begin
            if (qb.size() == 0) begin
                check("b_unexpected_output", 32'(b_down), 32'hDEAD_BEEF);
            end else begin
                e = qb.pop_front();
                check("b_down", 32'(b_down), 32'(e.down));
                check("b_ovf",  32'(b_ovf),  32'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; mode = 1'b0;
        in_left = 8'h0; in_left_vld = 1'b0; in_up = 24'h0; in_up_vld = 1'b0;
        w_in = 8'h0; w_load = 1'b0; w_swap = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic push(input logic [23:0] da, input logic [23:0] db, input logic [7:0] r,
                        input logic rv, input logic oa, input logic ob);
        exp_t e;
        e.down = da; e.right = r; e.rvld = rv; e.ovf = oa;
        qa.push_back(e);
        e.down = db; e.ovf = ob;
        qb.push_back(e);
    endtask

    // Both valids high, MAC mode; caller may add weight controls before ticking.
    task automatic mac(input logic [7:0] l, input logic [23:0] u, input logic [23:0] ea,
                       input logic [23:0] eb, input logic oa, input logic ob);
        idle();
        in_left = l; in_left_vld = 1'b1; in_up = u; in_up_vld = 1'b1;
        push(ea, eb, l, 1'b1, oa, ob);
    endtask

    task automatic load(input logic [7:0] w);
        idle(); w_in = w; w_load = 1'b1; tick();
    endtask

    task automatic swap();
        idle(); w_swap = 1'b1; tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_down"},  32'(a_down),  32'h0);
        check({tag, "_dvld"},  32'(a_dvld),  32'h0);
        check({tag, "_right"}, 32'(a_right), 32'h0);
        check({tag, "_rvld"},  32'(a_rvld),  32'h0);
        check({tag, "_ovf"},   32'(a_ovf),   32'h0);
        check({tag, "_svld"},  32'(a_svld),  32'h0);
        check({tag, "_wout"},  32'(a_wout),  32'h0);
        check({tag, "_b_down"}, 32'(b_down), 32'h0);
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("reset");
        tick();
        rst = 1'b0;

        // 1: swap with empty shadow leaves active at 0
        swap();
        check("t1_svld", 32'(a_svld), 32'h0);
        mac(8'd5, 24'd7, 24'd7, 24'd7, 1'b0, 1'b0); tick();

        // 2: weight -3, 4*-3 + 10 = -2
        load(8'hFD);
        check("t2_svld_full", 32'(a_svld), 32'h1);
        check("t2_wout", 32'(a_wout), 32'hFD);
        swap();
        check("t2_svld_empty", 32'(a_svld), 32'h0);
        mac(8'd4, 24'd10, 24'hFFFFFE, 24'hFFFFFE, 1'b0, 1'b0); tick();

        // 3: double buffering and swap timing
        load(8'd2); swap();
        mac(8'd3, 24'd0, 24'd6, 24'd6, 1'b0, 1'b0); w_in = 8'd9; w_load = 1'b1; tick();
        mac(8'd3, 24'd0, 24'd6, 24'd6, 1'b0, 1'b0); w_swap = 1'b1; tick();
        mac(8'd3, 24'd0, 24'd27, 24'd27, 1'b0, 1'b0); tick();
        load(8'd5);
        mac(8'd1, 24'd0, 24'd9, 24'd9, 1'b0, 1'b0); w_in = 8'd7; w_load = 1'b1; w_swap = 1'b1; tick();
        check("t3_ls_full_svld", 32'(a_svld), 32'h1);
        check("t3_ls_full_wout", 32'(a_wout), 32'h07);
        mac(8'd1, 24'd0, 24'd5, 24'd5, 1'b0, 1'b0); tick();
        swap();
        idle(); w_in = 8'd11; w_load = 1'b1; w_swap = 1'b1; tick();
        check("t3_ls_empty_svld", 32'(a_svld), 32'h1);
        check("t3_ls_empty_wout", 32'(a_wout), 32'h0B);
        mac(8'd1, 24'd0, 24'd7, 24'd7, 1'b0, 1'b0); tick();
        swap();

        // 4: saturation / wrap and sticky flag
        load(8'd127); swap();
        mac(8'd127, 24'h7FFFFF, 24'h7FFFFF, 24'h803F00, 1'b1, 1'b1); tick();
        idle(); clr_ovf = 1'b1; tick();
        check("t4_clr_a", 32'(a_ovf), 32'h0);
        check("t4_clr_b", 32'(b_ovf), 32'h0);
        mac(8'd127, 24'h7FFFFF, 24'h7FFFFF, 24'h803F00, 1'b1, 1'b1); clr_ovf = 1'b1; tick();
        idle(); clr_ovf = 1'b1; tick();
        mac(8'h80, 24'h800000, 24'h800000, 24'h7FC080, 1'b1, 1'b1); tick();
        idle(); clr_ovf = 1'b1; tick();
        check("t4_clr2_a", 32'(a_ovf), 32'h0);
        mac(8'd2, 24'h000999, 24'h0000FE, 24'h0000FE, 1'b0, 1'b0); in_up_vld = 1'b0; tick();
        idle(); in_up = 24'd55; in_up_vld = 1'b1; push(24'd55, 24'd55, 8'h0, 1'b0, 1'b0, 1'b0); tick();
        idle(); in_up = 24'h000777; tick();
        check("t4_idle_down", 32'(a_down), 32'h0);
        check("t4_idle_dvld", 32'(a_dvld), 32'h0);

        // 5: stall holds everything, then bypass
        mac(8'd127, 24'h7FFFFF, 24'h7FFFFF, 24'h803F00, 1'b1, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            en = 1'b0; mode = i[0]; clr_ovf = 1'b1; w_load = 1'b1; w_swap = 1'b1;
            w_in = 8'h55 + 8'(i); in_left = 8'h11 * 8'(i + 1); in_left_vld = ~i[0];
            in_up = 24'h0ABCDE; in_up_vld = i[0];
            tick();
            check("t5_down_a", 32'(a_down),  32'h7FFFFF);
            check("t5_down_b", 32'(b_down),  32'h803F00);
            check("t5_right",  32'(a_right), 32'h7F);
            check("t5_rvld",   32'(a_rvld),  32'h1);
            check("t5_dvld",   32'(a_dvld),  32'h1);
            check("t5_ovf",    32'(a_ovf),   32'h1);
            check("t5_svld",   32'(a_svld),  32'h0);
            check("t5_wout",   32'(a_wout),  32'h7F);
        end
        mac(8'd1, 24'd0, 24'd127, 24'd127, 1'b1, 1'b1); tick();
        idle(); clr_ovf = 1'b1; tick();
        mac(8'd127, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b0, 1'b0); mode = 1'b1; tick();
        idle(); mode = 1'b1; in_up = 24'h123456; in_up_vld = 1'b1;
        push(24'h123456, 24'h123456, 8'h0, 1'b0, 1'b0, 1'b0); tick();
        mac(8'd1, 24'd1, 24'd128, 24'd128, 1'b0, 1'b0); tick();

        // 6: asynchronous reset mid-stream
        load(8'h42);
        mac(8'd3, 24'd1, 24'h00017E, 24'h00017E, 1'b0, 1'b0); tick();
        idle(); in_left = 8'd9; in_left_vld = 1'b1; in_up = 24'd3; in_up_vld = 1'b1;
        #1 rst = 1'b1;
        qa.delete(); qb.delete();
        #1 check_zero("areset");
        tick();
        idle(); rst = 1'b0;
        check("t6_svld", 32'(a_svld), 32'h0);
        mac(8'd3, 24'd1, 24'd1, 24'd1, 1'b0, 1'b0); tick();
        idle(); tick(); tick();
        check("queue_a_drained", 32'(qa.size()), 32'h0);
        check("queue_b_drained", 32'(qb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
